estagio_ex_mem: RTL

ESTAGIO_EX_MEM -- requirements
Module: estagio_ex_mem

---
 rtl/exmem_pkg.sv | 25 ++
 rtl/estagio_ex_mem_resolve_desvio.sv | 39 +++
 rtl/estagio_ex_mem.sv | 129 ++++++++++++
 3 files changed

// File: rtl/exmem_pkg.sv
// Shared types for the EX/MEM pipeline register: buffer states, ctrl bit
// positions and the 73-bit entry record.
package exmem_pkg;

    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        UM    = 2'd1,
        CHEIO = 2'd2
    } estado_t;

    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_READ  = 2;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_BRANCH    = 0;

    localparam int ENTRY_W = 73;

    typedef struct packed {
        logic [31:0] resultado;
        logic [31:0] dados2;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } entrada_t;

endpackage

// File: rtl/estagio_ex_mem_resolve_desvio.sv
// Branch resolution for accepted EX results: registered one-cycle taken pulse
// plus the target address that goes with it.
module estagio_ex_mem_resolve_desvio
    import exmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        aceito,
    input  logic [3:0]  ctrl,
    input  logic        zero,
    input  logic        branch_ne,
    input  logic [31:0] pc_alvo,
    output logic        desvio,
    output logic [31:0] desvio_alvo
);

    logic        desvio_d, desvio_q;
    logic [31:0] alvo_d, alvo_q;

    always_comb begin
        desvio_d = aceito & ctrl[CTRL_BRANCH] & (zero ^ branch_ne);
        alvo_d   = alvo_q;
        if (desvio_d) alvo_d = pc_alvo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desvio_q <= 1'b0;
            alvo_q   <= '0;
        end else begin
            desvio_q <= desvio_d;
            alvo_q   <= alvo_d;
        end
    end

    assign desvio      = desvio_q;
    assign desvio_alvo = alvo_q;

endmodule

// File: rtl/estagio_ex_mem.sv
// EX/MEM pipeline register as a two-entry skid buffer with stall counter.
// Define EXMEM_DESVIO_EN to add branch resolution (desvio/desvio_alvo ports).
module estagio_ex_mem
    import exmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] resultado,
    input  logic        zero,
    input  logic [31:0] dados2,
    input  logic [4:0]  rd,
    input  logic [3:0]  ctrl,
    input  logic        branch_ne,
    input  logic [31:0] pc_alvo,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_resultado,
    output logic [31:0] out_dados2,
    output logic [4:0]  out_rd,
    output logic [3:0]  out_ctrl,
`ifdef EXMEM_DESVIO_EN
    output logic        desvio,
    output logic [31:0] desvio_alvo,
`endif
    output logic [15:0] ciclos_parado
);

    estado_t     state_d, state_q;
    entrada_t    head_d, head_q;
    entrada_t    skid_d, skid_q;
    entrada_t    entrada;
    logic        in_ready_d, in_ready_q;
    logic        out_valid_d, out_valid_q;
    logic [15:0] parado_d, parado_q;
    logic        accept, pop;

    assign entrada = '{resultado: resultado, dados2: dados2, rd: rd, ctrl: ctrl};
    assign accept  = in_valid & in_ready_q;
    assign pop     = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            VAZIO: begin
                if (accept) begin
                    head_d  = entrada;
                    state_d = UM;
                end
            end
            UM: begin
                if (accept && pop) begin
                    head_d = entrada;
                end else if (accept) begin
                    skid_d  = entrada;
                    state_d = CHEIO;
                end else if (pop) begin
                    state_d = VAZIO;
                end
            end
            CHEIO: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = UM;
                end
            end
            default: state_d = VAZIO;
        endcase
        // Flush drops everything but leaves the output data registers untouched
        if (flush) begin
            state_d = VAZIO;
            head_d  = head_q;
            skid_d  = skid_q;
        end
        in_ready_d  = (state_d != CHEIO);
        out_valid_d = (state_d != VAZIO);
        parado_d    = parado_q;
        if (in_valid && !in_ready_q && parado_q != 16'hFFFF)
            parado_d = parado_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= VAZIO;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            parado_q    <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            parado_q    <= parado_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_resultado = head_q.resultado;
    assign out_dados2    = head_q.dados2;
    assign out_rd        = head_q.rd;
    assign out_ctrl      = head_q.ctrl;
    assign ciclos_parado = parado_q;

`ifdef EXMEM_DESVIO_EN
    estagio_ex_mem_resolve_desvio u_desvio (
        .clk         (clk),
        .rst         (rst),
        .aceito      (accept & ~flush),
        .ctrl        (ctrl),
        .zero        (zero),
        .branch_ne   (branch_ne),
        .pc_alvo     (pc_alvo),
        .desvio      (desvio),
        .desvio_alvo (desvio_alvo)
    );
`else
    logic unused_desvio;
    assign unused_desvio = ^{zero, branch_ne, pc_alvo};
`endif

endmodule
